// File: rtl/hop_pkg.sv
// Shared definitions for the hop chain array: flush FSM state codes and
// helpers that size the tap-select and occupancy-count fields from DEPTH.
package hop_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int tap_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/hop_chain_array_if.sv
// Packed per-channel bus between stimulus and the hop chain array; channel c
// occupies slice [c*W +: W] of every multi-bit field.
interface hop_chain_array_if
  import hop_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 1,
  parameter int TAP_W    = tap_width(DEPTH),
  parameter int CNT_W    = cnt_width(DEPTH)
);

  logic [CHANNELS*WIDTH-1:0] start;
  logic [CHANNELS-1:0]       start_vld;
  logic [CHANNELS-1:0]       advance;
  logic [CHANNELS*DEPTH-1:0] stage_clr;
  logic [CHANNELS*TAP_W-1:0] tap_sel;
  logic [CHANNELS-1:0]       flush;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       dout_vld;
  logic [CHANNELS*WIDTH-1:0] tap_out;
  logic [CHANNELS*CNT_W-1:0] fill_cnt;
  logic [CHANNELS-1:0]       flush_busy;
  logic [CHANNELS-1:0]       flush_done;

  modport master (
    output start, start_vld, advance, stage_clr, tap_sel, flush,
    input  dout, dout_vld, tap_out, fill_cnt, flush_busy, flush_done
  );

  modport slave (
    input  start, start_vld, advance, stage_clr, tap_sel, flush,
    output dout, dout_vld, tap_out, fill_cnt, flush_busy, flush_done
  );

endinterface

// File: rtl/hop_chain_lane.sv
// One channel of the hop chain array: DEPTH data/valid stages with per-stage
// clear, a tap mux, an occupancy popcount and a self-timed flush sequencer.
module hop_chain_lane
  import hop_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1,
  parameter int TAP_W = tap_width(DEPTH),
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clock0,
  input  logic             rst1,
  input  logic [WIDTH-1:0] start,
  input  logic             start_vld,
  input  logic             advance,
  input  logic [DEPTH-1:0] stage_clr,
  input  logic [TAP_W-1:0] tap_sel,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic [WIDTH-1:0] tap_out,
  output logic [CNT_W-1:0] fill_cnt,
  output logic             flush_busy,
  output logic             flush_done
);

  logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [1:0]                  state_q, state_d;
  logic                        draining;
  logic                        eff_adv;

  assign draining = (state_q == ST_DRAIN);
  assign eff_adv  = draining || advance;

  // NOTE: every always_comb output gets a full default first so no path
  // through the block leaves a value unassigned and infers a latch.
  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (eff_adv) begin
      dat_d[0] = draining ? '0 : start;
      vld_d[0] = !draining && start_vld;
      for (int k = 1; k < DEPTH; k++) begin
        dat_d[k] = dat_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
    end
    // Clear wins over the incoming shift; stage k+1 already took old stage k.
    for (int k = 0; k < DEPTH; k++) begin
      if (stage_clr[k]) begin
        dat_d[k] = '0;
        vld_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flush) state_d = (|vld_q) ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (vld_d == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: the stage registers are ordinary flops, not RAM, so they are all
  // reset; dout/fill_cnt must read 0 straight after reset.
  always_ff @(posedge clock0) begin
    if (rst1) begin
      dat_q   <= '0;
      vld_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking updates so every stage samples the pre-edge
      // value of its neighbour, independent of statement order.
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    tap_out = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_sel == TAP_W'(k)) tap_out = dat_q[k];
    end
  end

  always_comb begin
    fill_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fill_cnt = fill_cnt + CNT_W'(vld_q[k]);
    end
  end

  assign dout       = dat_q[DEPTH-1];
  assign dout_vld   = vld_q[DEPTH-1];
  assign flush_busy = (state_q == ST_DRAIN);
  assign flush_done = (state_q == ST_DONE);

endmodule

// File: rtl/hop_chain_array.sv
// Array of CHANNELS independent hop chains; slices the packed interface bus
// into one hop_chain_lane per channel.
module hop_chain_array
  import hop_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 1,
  parameter int TAP_W    = tap_width(DEPTH),
  parameter int CNT_W    = cnt_width(DEPTH)
) (
  input logic               clock0,
  input logic               rst1,
  hop_chain_array_if.slave  bus
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    hop_chain_lane #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .TAP_W (TAP_W),
      .CNT_W (CNT_W)
    ) u_lane (
      .clock0     (clock0),
      .rst1       (rst1),
      .start      (bus.start[c*WIDTH +: WIDTH]),
      .start_vld  (bus.start_vld[c]),
      .advance    (bus.advance[c]),
      .stage_clr  (bus.stage_clr[c*DEPTH +: DEPTH]),
      .tap_sel    (bus.tap_sel[c*TAP_W +: TAP_W]),
      .flush      (bus.flush[c]),
      .dout       (bus.dout[c*WIDTH +: WIDTH]),
      .dout_vld   (bus.dout_vld[c]),
      .tap_out    (bus.tap_out[c*WIDTH +: WIDTH]),
      .fill_cnt   (bus.fill_cnt[c*CNT_W +: CNT_W]),
      .flush_busy (bus.flush_busy[c]),
      .flush_done (bus.flush_done[c])
    );
  end

endmodule

// File: tb/tb_hop_chain_array.sv
// Self-checking bench for hop_chain_array: per-channel array model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_hop_chain_array;

  localparam int CH  = 4;
  localparam int D   = 8;
  localparam int W   = 1;
  localparam int TW  = 3;
  localparam int CW  = 4;
  localparam int SW  = CH * W;

  localparam int CH2 = 2;
  localparam int D2  = 10;
  localparam int W2  = 4;
  localparam int TW2 = 4;
  localparam int CW2 = 4;

  logic clock0 = 1'b0;
  logic rst1;
  always #5 clock0 = ~clock0;

  hop_chain_array_if #(.CHANNELS(CH), .DEPTH(D), .WIDTH(W), .TAP_W(TW), .CNT_W(CW)) bus ();
  hop_chain_array_if #(.CHANNELS(CH2), .DEPTH(D2), .WIDTH(W2), .TAP_W(TW2), .CNT_W(CW2)) bus2 ();

  hop_chain_array #(.CHANNELS(CH), .DEPTH(D), .WIDTH(W), .TAP_W(TW), .CNT_W(CW)) dut (
    .clock0 (clock0),
    .rst1   (rst1),
    .bus    (bus)
  );

  hop_chain_array #(.CHANNELS(CH2), .DEPTH(D2), .WIDTH(W2), .TAP_W(TW2), .CNT_W(CW2)) dut10 (
    .clock0 (clock0),
    .rst1   (rst1),
    .bus    (bus2)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: each chain is an array of (data, valid) cells plus a
  // mode number 0=idle 1=drain 2=done.
  int m_dat [CH][D];
  bit m_vld [CH][D];
  int m_st  [CH];

  function automatic int m_fill(input int c);
    int n = 0;
    for (int k = 0; k < D; k++) n += int'(m_vld[c][k]);
    return n;
  endfunction

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int  nd [D];
      bit  nv [D];
      bit  drain, shift, any;
      if (rst1) begin
        for (int k = 0; k < D; k++) begin
          m_dat[c][k] = 0;
          m_vld[c][k] = 1'b0;
        end
        m_st[c] = 0;
      end else begin
        drain = (m_st[c] == 1);
        shift = drain || bus.advance[c];
        for (int k = 0; k < D; k++) begin
          nd[k] = m_dat[c][k];
          nv[k] = m_vld[c][k];
        end
        if (shift) begin
          for (int k = D - 1; k > 0; k--) begin
            nd[k] = m_dat[c][k-1];
            nv[k] = m_vld[c][k-1];
          end
          nd[0] = drain ? 0 : int'(bus.start[c*W +: W]);
          nv[0] = drain ? 1'b0 : bus.start_vld[c];
        end
        any = 1'b0;
        for (int k = 0; k < D; k++) begin
          if (bus.stage_clr[c*D + k]) begin
            nd[k] = 0;
            nv[k] = 1'b0;
          end
          any |= nv[k];
        end
        case (m_st[c])
          0: if (bus.flush[c]) m_st[c] = (m_fill(c) != 0) ? 1 : 2;
          1: if (!any) m_st[c] = 2;
          default: m_st[c] = 0;
        endcase
        for (int k = 0; k < D; k++) begin
          m_dat[c][k] = nd[k];
          m_vld[c][k] = nv[k];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) begin
      int ts;
      int exp_tap;
      ts      = int'(bus.tap_sel[c*TW +: TW]);
      exp_tap = (ts < D) ? m_dat[c][ts] : 0;
      check($sformatf("ch%0d dout", c), 32'(bus.dout[c*W +: W]), 32'(m_dat[c][D-1]));
      check($sformatf("ch%0d dout_vld", c), 32'(bus.dout_vld[c]), 32'(m_vld[c][D-1]));
      check($sformatf("ch%0d tap_out", c), 32'(bus.tap_out[c*W +: W]), 32'(exp_tap));
      check($sformatf("ch%0d fill_cnt", c), 32'(bus.fill_cnt[c*CW +: CW]), 32'(m_fill(c)));
      check($sformatf("ch%0d flush_busy", c), 32'(bus.flush_busy[c]), 32'(m_st[c] == 1));
      check($sformatf("ch%0d flush_done", c), 32'(bus.flush_done[c]), 32'(m_st[c] == 2));
    end
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_st[c] = 0;
      for (int k = 0; k < D; k++) begin
        m_dat[c][k] = 0;
        m_vld[c][k] = 1'b0;
      end
    end
    forever begin
      @(posedge clock0);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock0);
      if (cmp_en) compare_all();
    end
  end

  task automatic cyc();
    @(posedge clock0);
    #2;
  endtask

  task automatic clear_inputs();
    bus.start     = '0;
    bus.start_vld = '0;
    bus.advance   = '0;
    bus.stage_clr = '0;
    bus.tap_sel   = '0;
    bus.flush     = '0;
  endtask

  initial begin
    int n;
    int nb;
    int nd;
    rst1 = 1'b1;
    clear_inputs();
    bus2.start     = '0;
    bus2.start_vld = '0;
    bus2.advance   = '0;
    bus2.stage_clr = '0;
    bus2.tap_sel   = '0;
    bus2.flush     = '0;
    cyc();
    rst1   = 1'b0;
    cmp_en = 1'b1;

    check("reset dout", 32'(bus.dout), 0);
    check("reset dout_vld", 32'(bus.dout_vld), 0);
    check("reset tap_out", 32'(bus.tap_out), 0);
    check("reset fill_cnt", 32'(bus.fill_cnt), 0);
    check("reset busy", 32'(bus.flush_busy), 0);
    check("reset done", 32'(bus.flush_done), 0);

    // Latency on ch0: one valid word, advance held.
    bus.start[0]     = 1'b1;
    bus.start_vld[0] = 1'b1;
    bus.advance[0]   = 1'b1;
    cyc();
    bus.start[0]     = 1'b0;
    bus.start_vld[0] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      if (e <= 8) check($sformatf("t1 fill@%0d", e), 32'(bus.fill_cnt[0 +: CW]), 1);
      if (e == 7) check("t1 dout_vld@7", 32'(bus.dout_vld[0]), 0);
      if (e == 8) begin
        check("t1 dout_vld@8", 32'(bus.dout_vld[0]), 1);
        check("t1 dout@8", 32'(bus.dout[0]), 1);
      end
      if (e == 9) check("t1 dout_vld@9", 32'(bus.dout_vld[0]), 0);
      if (e < 9) cyc();
    end

    // Stall on ch1: advance 1,0,0,1,... counts advance edges, not clocks.
    bus.tap_sel[1*TW +: TW] = 3'd3;
    bus.start[1]     = 1'b1;
    bus.start_vld[1] = 1'b1;
    bus.advance[1]   = 1'b1;
    cyc();
    n = 1;
    bus.start[1]     = 1'b0;
    bus.start_vld[1] = 1'b0;
    for (int j = 1; j < 40 && n < 8; j++) begin
      bus.advance[1] = (j % 3 == 0);
      cyc();
      if (bus.advance[1]) n++;
      check("t2 fill", 32'(bus.fill_cnt[1*CW +: CW]), 1);
      if (n == 4 && bus.advance[1]) check("t2 tap@3", 32'(bus.tap_out[1]), 1);
      check("t2 dout_vld", 32'(bus.dout_vld[1]), 32'(n >= 8));
    end
    check("t2 advance edges", 32'(n), 8);
    check("t2 dout", 32'(bus.dout[1]), 1);
    bus.advance[1] = 1'b0;

    // Stage clear priority on a full ch2.
    bus.start[2]     = 1'b1;
    bus.start_vld[2] = 1'b1;
    bus.advance[2]   = 1'b1;
    repeat (D) cyc();
    check("t3 full", 32'(bus.fill_cnt[2*CW +: CW]), 8);
    bus.tap_sel[2*TW +: TW] = 3'd4;
    bus.stage_clr[2*D + 4]  = 1'b1;
    cyc();
    bus.stage_clr = '0;
    bus.advance[2] = 1'b0;
    bus.start_vld[2] = 1'b0;
    bus.start[2] = 1'b0;
    check("t3 fill", 32'(bus.fill_cnt[2*CW +: CW]), 7);
    check("t3 stage4", 32'(bus.tap_out[2]), 0);
    bus.tap_sel[2*TW +: TW] = 3'd5;
    #1;
    check("t3 stage5", 32'(bus.tap_out[2]), 1);

    // Flush ch3 holding words at stages 0..2 while advance=0, start_vld=1.
    for (int i = 0; i < 3; i++) begin
      bus.start[3]     = (i != 1);
      bus.start_vld[3] = 1'b1;
      bus.advance[3]   = 1'b1;
      cyc();
    end
    check("t4 fill", 32'(bus.fill_cnt[3*CW +: CW]), 3);
    bus.advance[3] = 1'b0;
    bus.start[3]   = 1'b1;
    bus.flush[3]   = 1'b1;
    cyc();
    bus.flush[3] = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.flush_busy[3]) nb++;
      if (bus.flush_done[3]) nd++;
      cyc();
    end
    check("t4 busy cycles", 32'(nb), 8);
    check("t4 done pulses", 32'(nd), 1);
    check("t4 fill after", 32'(bus.fill_cnt[3*CW +: CW]), 0);
    bus.start_vld[3] = 1'b0;
    bus.start[3]     = 1'b0;

    // DEPTH=10 build: full tap range and out-of-range selects.
    for (int i = 0; i < D2; i++) begin
      bus2.start[0 +: W2]  = W2'(i + 1);
      bus2.start_vld[0]    = 1'b1;
      bus2.advance[0]      = 1'b1;
      cyc();
    end
    bus2.advance = '0;
    bus2.start_vld = '0;
    check("t6 d10 dout", 32'(bus2.dout[0 +: W2]), 1);
    check("t6 d10 fill", 32'(bus2.fill_cnt[0 +: CW2]), 10);
    check("t6 d10 ch1 fill", 32'(bus2.fill_cnt[CW2 +: CW2]), 0);
    bus2.tap_sel[0 +: TW2] = 4'd9;
    #1 check("t6 d10 tap9", 32'(bus2.tap_out[0 +: W2]), 1);
    bus2.tap_sel[0 +: TW2] = 4'd0;
    #1 check("t6 d10 tap0", 32'(bus2.tap_out[0 +: W2]), 10);
    bus2.tap_sel[0 +: TW2] = 4'd10;
    #1 check("t6 d10 tap10", 32'(bus2.tap_out[0 +: W2]), 0);
    bus2.tap_sel[0 +: TW2] = 4'd15;
    #1 check("t6 d10 tap15", 32'(bus2.tap_out[0 +: W2]), 0);

    // Flush of an empty channel: immediate done, never busy.
    bus.flush[3] = 1'b1;
    cyc();
    bus.flush[3] = 1'b0;
    check("t5 empty done", 32'(bus.flush_done[3]), 1);
    check("t5 empty busy", 32'(bus.flush_busy[3]), 0);
    cyc();
    check("t5 empty done end", 32'(bus.flush_done[3]), 0);

    // Reset during the third drain cycle of ch0.
    bus.start[0]     = 1'b1;
    bus.start_vld[0] = 1'b1;
    bus.advance[0]   = 1'b1;
    repeat (2) cyc();
    bus.start_vld[0] = 1'b0;
    bus.flush[0]     = 1'b1;
    cyc();
    bus.flush[0] = 1'b0;
    check("t5 drain start", 32'(bus.flush_busy[0]), 1);
    repeat (2) cyc();
    check("t5 drain 3rd", 32'(bus.flush_busy[0]), 1);
    rst1 = 1'b1;
    cyc();
    rst1 = 1'b0;
    clear_inputs();
    check("t5 rst dout", 32'(bus.dout), 0);
    check("t5 rst dout_vld", 32'(bus.dout_vld), 0);
    check("t5 rst fill", 32'(bus.fill_cnt), 0);
    check("t5 rst busy", 32'(bus.flush_busy), 0);
    check("t5 rst done", 32'(bus.flush_done), 0);
    cyc();
    check("t5 no done after rst", 32'(bus.flush_done), 0);

    // Random traffic on all channels against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.start     = SW'($urandom);
      bus.start_vld = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        bus.advance[c]         = ($urandom_range(0, 3) != 0);
        bus.flush[c]           = ($urandom_range(0, 11) == 0);
        bus.tap_sel[c*TW +: TW] = TW'($urandom);
        for (int k = 0; k < D; k++) bus.stage_clr[c*D + k] = ($urandom_range(0, 23) == 0);
      end
      rst1 = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst1 = 1'b0;
    clear_inputs();
    cyc();

    @(negedge clock0);
    #1;
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
